// File: rtl/lsu_rmw.sv
// Load/store initiator for a word-wide 1-cycle-read RAM: byte/half/word access, sub-word RMW,
// load extension. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_rmw #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH) + 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write_en,
    output logic [AW-1:0]     mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StResp} state_t;

    state_t            r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_we;
    logic [31:0]       r_mem_wdata;

    logic              w_misalign;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            2'd0:    w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word comes back from RAM unchanged.
    always_comb begin
        w_merge = mem_rdata;
        case (r_size)
            2'd0:    w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'd1:    w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_misalign) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= StResp;
                        end else if (req_we && req_size[1]) begin
                            r_mem_wdata <= req_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= StWrite;
                        end else begin
                            r_state <= StRead;
                        end
                    end
                end
                StRead: r_state <= StWait;
                StWait: begin
                    if (r_we) begin
                        r_mem_wdata <= w_merge;
                        r_mem_we    <= 1'b1;
                        r_state     <= StWrite;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end
                end
                StWrite: begin
                    r_resp_rdata <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= StResp;
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready    = (r_state == StIdle) && !reset;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign mem_write_en = r_mem_we;
    assign mem_addr     = r_addr[ADDR_W-1:2];
    assign mem_wdata    = r_mem_wdata;

endmodule
